// File: rtl/nios_system_com_nios_oci_dct_pkg.sv
// Shared types and widths for the OCI direct-compressed-trace scheduler.
// Imported by the scheduler top, its holding register and the bus interface.
package nios_system_com_nios_oci_dct_pkg;

    localparam int SYM_W     = 2;
    localparam int DEF_SLOTS = 15;
    localparam int COUNT_W   = 4;
    localparam int OUT_W     = 34;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL_WAIT
    } state_e;

endpackage

// File: rtl/nios_system_com_nios_oci_dct_sched_if.sv
// Symbol input and packed-word output handshake of the DCT scheduler.
// The master side drives symbols and accepts words; the slave side is the scheduler.
interface nios_system_com_nios_oci_dct_sched_if;
    import nios_system_com_nios_oci_dct_pkg::*;

    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             flush_req;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;

    modport master (
        output sym_valid, sym_data, flush_req, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  sym_valid, sym_data, flush_req, out_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/nios_system_com_nios_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed trace words.
// A load in the same cycle as a handshake keeps valid asserted.
module nios_system_com_nios_oci_dct_outreg
    import nios_system_com_nios_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [OUT_W-1:0] data,
    output logic             hold_free
);

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        hold_free = !valid_q || ready;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/nios_system_com_nios_oci_dct_sched.sv
// DCT scheduler: packs 2-bit trace symbols LSB-first into a 15-slot buffer
// and hands full, flushed, timed-out or trace-disabled words to the FIFO.
module nios_system_com_nios_oci_dct_sched
    import nios_system_com_nios_oci_dct_pkg::*;
#(
    parameter int SLOTS   = DEF_SLOTS,
    parameter int TIMEOUT = 255,
    parameter int TMR_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       trace_en,
    nios_system_com_nios_oci_dct_sched_if.slave bus,
    input  logic                       clr_overflow,
    output logic [SYM_W*SLOTS-1:0]     dct_buffer,
    output logic [COUNT_W-1:0]         dct_count,
    output logic                       overflow
);

    localparam int BUF_W = SYM_W * SLOTS;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(SLOTS);
    localparam logic [TMR_W-1:0]   TMR_MAX  = TMR_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d, eff_buf;
    logic [COUNT_W-1:0] cnt_q, cnt_d, eff_cnt;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               en_q, en_d;
    logic               accept, drop, has_data, is_full;
    logic               emit, load, hold_free;
    logic [OUT_W-1:0]   word;

    always_comb begin
        accept   = bus.sym_valid && trace_en && (state_q != FULL_WAIT);
        drop     = bus.sym_valid && trace_en && (state_q == FULL_WAIT);
        eff_buf  = buf_q;
        eff_cnt  = cnt_q;
        if (accept) begin
            eff_buf = buf_q | (BUF_W'(bus.sym_data) << {cnt_q, 1'b0});
            eff_cnt = cnt_q + 1'b1;
        end
        has_data = (eff_cnt != '0);
        is_full  = (eff_cnt == FULL_CNT);
        // Timeout looks at the registered count: an accept restarts the idle window.
        emit = is_full
            || ((bus.flush_req || pend_q) && has_data)
            || ((tmr_q == TMR_MAX) && (cnt_q != '0) && !accept)
            || (en_q && !trace_en && has_data);
        load = emit && hold_free;
        word = {eff_cnt, eff_buf};
    end

    always_comb begin
        buf_d   = eff_buf;
        cnt_d   = eff_cnt;
        pend_d  = pend_q;
        state_d = state_q;
        en_d    = trace_en;
        priority case (1'b1)
            load: begin
                buf_d   = '0;
                cnt_d   = '0;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            emit && is_full: begin
                state_d = FULL_WAIT;
            end
            default: begin
                if (emit) pend_d = 1'b1;
                state_d = has_data ? FILL : IDLE;
            end
        endcase
        if (accept || load || (cnt_d == '0)) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + 1'b1;
        end else begin
            tmr_d = tmr_q;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
        end
    end

    nios_system_com_nios_oci_dct_outreg u_outreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (word),
        .ready     (bus.out_ready),
        .valid     (bus.out_valid),
        .data      (bus.out_data),
        .hold_free (hold_free)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = ovf_q;

endmodule
